proc_control_unit: RTL and testbench



---
 rtl/proc_control_unit.sv | 133 +++++++++++++
 tb/tb_proc_control_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// Instruction sequencer for the LAOC II register-transfer datapath.
// Optional feature: define CU_MVNZ_EN to turn opcode 111 into mvnz.
module proc_control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] din,
    input  logic        g_nz,
    output logic [3:0]  sel,
    output logic [7:0]  r_in,
    output logic        a_in,
    output logic        g_in,
    output logic [1:0]  alu_op,
    output logic        ir_load,
    output logic        done
);

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

    localparam logic [3:0] SelG   = 4'd8;
    localparam logic [3:0] SelDin = 4'd9;

    step_t      step_q, step_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode, x, y;
    logic [2:0] alu_sel;

    assign opcode  = ir_q[8:6];
    assign x       = ir_q[5:3];
    assign y       = ir_q[2:0];
    assign alu_sel = opcode - 3'd2;

`ifdef CU_MVNZ_EN
    logic unused_bits;
    assign unused_bits = ^din[15:9];
`else
    logic unused_bits;
    assign unused_bits = ^{din[15:9], g_nz};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_q <= T0;
            ir_q   <= 9'd0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    always_comb begin
        step_d  = step_q;
        ir_d    = ir_q;
        sel     = 4'd0;
        r_in    = 8'd0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = 2'b00;
        ir_load = 1'b0;
        done    = 1'b0;

        unique case (step_q)
            T0: begin
                if (run) begin
                    ir_load = 1'b1;
                    ir_d    = din[8:0];
                    step_d  = T1;
                end
            end
            T1: begin
                case (opcode)
                    3'b000: begin
                        sel    = {1'b0, y};
                        r_in   = 8'd1 << x;
                        done   = 1'b1;
                        step_d = T0;
                    end
                    3'b001: begin
                        sel    = SelDin;
                        r_in   = 8'd1 << x;
                        done   = 1'b1;
                        step_d = T0;
                    end
                    3'b010, 3'b011, 3'b100, 3'b101: begin
                        sel    = {1'b0, x};
                        a_in   = 1'b1;
                        step_d = T2;
                    end
`ifdef CU_MVNZ_EN
                    3'b111: begin
                        if (g_nz) begin
                            sel  = {1'b0, y};
                            r_in = 8'd1 << x;
                        end
                        done   = 1'b1;
                        step_d = T0;
                    end
`endif
                    default: begin
                        done   = 1'b1;
                        step_d = T0;
                    end
                endcase
            end
            T2: begin
                sel    = {1'b0, y};
                g_in   = 1'b1;
                alu_op = alu_sel[1:0];
                step_d = T3;
            end
            T3: begin
                sel    = SelG;
                r_in   = 8'd1 << x;
                done   = 1'b1;
                step_d = T0;
            end
            default: step_d = T0;
        endcase

        // Outputs are forced quiet while reset is held so nothing leaks from an aborted step.
        if (reset) begin
            sel     = 4'd0;
            r_in    = 8'd0;
            a_in    = 1'b0;
            g_in    = 1'b0;
            alu_op  = 2'b00;
            ir_load = 1'b0;
            done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit; outputs are packed as
// {sel, r_in, a_in, g_in, alu_op, ir_load, done} for each comparison.
module tb_proc_control_unit;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic        g_nz;
    logic [3:0]  sel;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic [1:0]  alu_op;
    logic        ir_load;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic abort_watch = 1'b0;
    logic rin_seen    = 1'b0;

    proc_control_unit dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .din     (din),
        .g_nz    (g_nz),
        .sel     (sel),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .alu_op  (alu_op),
        .ir_load (ir_load),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or r_in) begin
        if (abort_watch && (r_in !== 8'd0)) rin_seen = 1'b1;
    end

    function automatic logic [17:0] pk(input logic [3:0] s, input logic [7:0] r, input logic a,
                                       input logic g, input logic [1:0] op, input logic il,
                                       input logic dn);
        return {s, r, a, g, op, il, dn};
    endfunction

    function automatic logic [17:0] outs();
        return {sel, r_in, a_in, g_in, alu_op, ir_load, done};
    endfunction

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    localparam logic [17:0] Idle  = 18'd0;
    localparam logic [17:0] Fetch = 18'd2;

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        din   = 16'h01FF;
        g_nz  = 1'b0;
        #3;
        check("reset_quiet", outs(), Idle);

        // Release with run high: fetch mv R3,R5 on the first edge.
        @(negedge clock);
        reset = 1'b0;
        din   = 16'h001D;
        #1;
        check("mv_fetch", outs(), Fetch);
        step();
        run = 1'b0;
        #1;
        check("mv_t1", outs(), pk(4'd5, 8'h08, 0, 0, 2'b00, 0, 1));
        step();
        check("mv_idle", outs(), Idle);
        step();
        check("idle_hold", outs(), Idle);

        // mvi R7 with immediate on din during T1.
        run = 1'b1;
        din = 16'h0078;
        #1;
        check("mvi_fetch", outs(), Fetch);
        step();
        run = 1'b0;
        din = 16'h00A5;
        #1;
        check("mvi_t1", outs(), pk(4'd9, 8'h80, 0, 0, 2'b00, 0, 1));
        step();
        check("mvi_idle", outs(), Idle);

        // sub R1,R2
        run = 1'b1;
        din = 16'h00CA;
        #1;
        check("sub_fetch", outs(), Fetch);
        step();
        run = 1'b0;
        #1;
        check("sub_t1", outs(), pk(4'd1, 8'h00, 1, 0, 2'b00, 0, 0));
        step();
        check("sub_t2", outs(), pk(4'd2, 8'h00, 0, 1, 2'b01, 0, 0));
        step();
        check("sub_t3", outs(), pk(4'd8, 8'h02, 0, 0, 2'b00, 0, 1));
        step();
        check("sub_idle", outs(), Idle);

        // add R0,R1 then mv R2,R0 back to back, run toggled mid-instruction.
        run = 1'b1;
        din = 16'h0081;
        #1;
        check("add_fetch", outs(), Fetch);
        step();
        din = 16'h0010;
        run = 1'b0;
        #1;
        check("add_t1", outs(), pk(4'd0, 8'h00, 1, 0, 2'b00, 0, 0));
        step();
        run = 1'b1;
        #1;
        check("add_t2", outs(), pk(4'd1, 8'h00, 0, 1, 2'b00, 0, 0));
        step();
        check("add_t3", outs(), pk(4'd8, 8'h01, 0, 0, 2'b00, 0, 1));
        step();
        check("b2b_fetch", outs(), Fetch);
        step();
        check("b2b_mv_t1", outs(), pk(4'd0, 8'h04, 0, 0, 2'b00, 0, 1));
        run = 1'b0;
        step();
        check("b2b_idle", outs(), Idle);

        // or R4,R6 aborted by reset in T2.
        run = 1'b1;
        din = 16'h0166;
        #1;
        check("or_fetch", outs(), Fetch);
        step();
        run = 1'b0;
        #1;
        check("or_t1", outs(), pk(4'd4, 8'h00, 1, 0, 2'b00, 0, 0));
        step();
        check("or_t2", outs(), pk(4'd6, 8'h00, 0, 1, 2'b11, 0, 0));
        abort_watch = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("abort_immediate", outs(), Idle);
        run = 1'b1;
        step();
        check("abort_held", outs(), Idle);
        @(negedge clock);
        run   = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_release", outs(), Idle);
        step();
        check("abort_stay_t0", outs(), Idle);
        step();
        check("abort_stay_t0b", outs(), Idle);
        abort_watch = 1'b0;
        check("abort_no_rin", {17'd0, rin_seen}, 18'd0);

        // Reset released while run high with mv R1,R6.
        reset = 1'b1;
        run   = 1'b1;
        din   = 16'h000E;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rel_fetch", outs(), Fetch);
        step();
        run = 1'b0;
        #1;
        check("rel_mv_t1", outs(), pk(4'd6, 8'h02, 0, 0, 2'b00, 0, 1));
        step();

        // Reserved opcode 110.
        run = 1'b1;
        din = 16'h0191;
        #1;
        check("rsv_fetch", outs(), Fetch);
        step();
        run = 1'b0;
        #1;
        check("rsv_t1", outs(), pk(4'd0, 8'h00, 0, 0, 2'b00, 0, 1));
        step();
        check("rsv_idle", outs(), Idle);

        // Opcode 111 with X=5, Y=3; g_nz flipped inside T1.
        run  = 1'b1;
        din  = 16'h01EB;
        g_nz = 1'b0;
        #1;
        check("op7_fetch", outs(), Fetch);
        step();
        run = 1'b0;
        #1;
        check("op7_gnz0", outs(), pk(4'd0, 8'h00, 0, 0, 2'b00, 0, 1));
        g_nz = 1'b1;
        #1;
`ifdef CU_MVNZ_EN
        check("op7_gnz1", outs(), pk(4'd3, 8'h20, 0, 0, 2'b00, 0, 1));
`else
        check("op7_gnz1", outs(), pk(4'd0, 8'h00, 0, 0, 2'b00, 0, 1));
`endif
        step();
        g_nz = 1'b0;
        check("op7_idle", outs(), Idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
